// File: rtl/cmp_bit_serializer_if.sv
// Word-pair handshake and bit-serial output bundle for cmp_bit_serializer.
// Carries exp_eq/exp_valid when CMP_SELFCHECK_EN is defined.
interface cmp_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             x;
    logic             y;
    logic             bit_valid;
    logic             bit_first;
    logic             bit_last;
    logic             busy;
`ifdef CMP_SELFCHECK_EN
    logic             exp_eq;
    logic             exp_valid;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, x, y, bit_valid, bit_first, bit_last, busy,
        input  exp_eq, exp_valid
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, x, y, bit_valid, bit_first, bit_last, busy,
        output exp_eq, exp_valid
    );
`else
    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, x, y, bit_valid, bit_first, bit_last, busy
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, x, y, bit_valid, bit_first, bit_last, busy
    );
`endif
endinterface

// File: rtl/cmp_bit_serializer.sv
// MSB-first serializer of an (A,B) word pair into x/y bit pairs with framing.
// Optional reference-equality outputs are enabled by CMP_SELFCHECK_EN.
module cmp_bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cmp_bit_serializer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
    localparam logic [3:0]      GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gap;
    logic             r_x;
    logic             r_y;
    logic             r_bv;
    logic             r_first;
    logic             r_last;
    logic             r_busy;

    state_t           w_state;
    logic [WIDTH-1:0] w_sa;
    logic [WIDTH-1:0] w_sb;
    logic [CW-1:0]    w_cnt;
    logic [3:0]       w_gap;
    logic             w_bv;
    logic             w_x;
    logic             w_y;
    logic             w_first;
    logic             w_last;
    logic             w_busy;

`ifdef CMP_SELFCHECK_EN
    logic             r_eq;
    logic             r_exp_eq;
    logic             r_exp_valid;
    logic             w_eq;
`endif

    assign bus.in_ready = (r_state == S_IDLE) & ~rst;

    always_comb begin
        w_state = r_state;
        w_sa    = r_sa;
        w_sb    = r_sb;
        w_cnt   = r_cnt;
        w_gap   = r_gap;
`ifdef CMP_SELFCHECK_EN
        w_eq    = r_eq;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state = S_SHIFT;
                    w_sa    = bus.in_a;
                    w_sb    = bus.in_b;
                    w_cnt   = '0;
`ifdef CMP_SELFCHECK_EN
                    w_eq    = &(~(bus.in_a ^ bus.in_b));
`endif
                end
            end
            S_SHIFT: begin
                w_sa = r_sa << 1;
                w_sb = r_sb << 1;
                if (r_cnt == LAST) begin
                    // Counter parks at 0 so it never runs past WIDTH-1
                    w_cnt   = '0;
                    w_gap   = '0;
                    w_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state = S_IDLE;
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the next-state values
        w_bv    = (w_state == S_SHIFT);
        w_x     = w_bv & w_sa[WIDTH-1];
        w_y     = w_bv & w_sb[WIDTH-1];
        w_first = w_bv & (w_cnt == '0);
        w_last  = w_bv & (w_cnt == LAST);
        w_busy  = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_bv    <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
            r_x     <= w_x;
            r_y     <= w_y;
            r_bv    <= w_bv;
            r_first <= w_first;
            r_last  <= w_last;
            r_busy  <= w_busy;
        end
    end

    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.bit_valid = r_bv;
    assign bus.bit_first = r_first;
    assign bus.bit_last  = r_last;
    assign bus.busy      = r_busy;

`ifdef CMP_SELFCHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eq        <= 1'b0;
            r_exp_eq    <= 1'b0;
            r_exp_valid <= 1'b0;
        end else begin
            r_eq        <= w_eq;
            r_exp_eq    <= w_last & w_eq;
            r_exp_valid <= w_last;
        end
    end

    assign bus.exp_eq    = r_exp_eq;
    assign bus.exp_valid = r_exp_valid;
`endif

endmodule

// File: tb/tb_cmp_bit_serializer.sv
// Scoreboard bench for cmp_bit_serializer: WIDTH=8/GAP=1 and WIDTH=1/GAP=0.
// Directed test-plan words followed by randomized traffic and resets.
module tb_cmp_bit_serializer;

    localparam int W8 = 8;
    localparam int G8 = 1;
    localparam int W1 = 1;
    localparam int G1 = 0;

    typedef struct {
        int   cyc;
        logic x;
        logic y;
        logic f;
        logic l;
        logic eq;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   rdy8 = 0;
    int   rdy1 = 0;
    bit   done = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    ent_t q8[$];
    ent_t q1[$];

    cmp_bit_serializer_if #(.WIDTH(W8)) b8 ();
    cmp_bit_serializer_if #(.WIDTH(W1)) b1 ();

    cmp_bit_serializer #(.WIDTH(W8), .GAP_CYCLES(G8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    cmp_bit_serializer #(.WIDTH(W1), .GAP_CYCLES(G1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: word k accepted at the end of cycle c emits its bits
    // in cycles c+1..c+W and the block is ready again at c+W+G+1.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                while (q8.size() > 0 && q8[$].cyc > cyc) void'(q8.pop_back());
                while (q1.size() > 0 && q1[$].cyc > cyc) void'(q1.pop_back());
                rdy8 = cyc + 1;
                rdy1 = cyc + 1;
            end else begin
                if (b8.in_valid === 1'b1 && cyc >= rdy8) begin
                    for (int i = 0; i < W8; i++) begin
                        q8.push_back('{cyc + 1 + i, b8.in_a[W8-1-i], b8.in_b[W8-1-i],
                                       i == 0, i == W8 - 1, b8.in_a == b8.in_b});
                    end
                    rdy8 = cyc + W8 + G8 + 1;
                end
                if (b1.in_valid === 1'b1 && cyc >= rdy1) begin
                    q1.push_back('{cyc + 1, b1.in_a[0], b1.in_b[0], 1'b1, 1'b1,
                                   b1.in_a == b1.in_b});
                    rdy1 = cyc + W1 + G1 + 1;
                end
            end
            cyc = cyc + 1;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard each cycle
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("q8_drained", q8.size(), 0);
                chk("q1_drained", q1.size(), 0);
                $display("End of test - %0d assertions evaluated, %0d failures",
                         n_checks, n_fail);
                $finish;
            end
            if (cyc > 0) begin
                chk("rdy8", int'(b8.in_ready), int'(!rst && cyc >= rdy8));
                chk("busy8", int'(b8.busy), int'(cyc < rdy8));
                if (q8.size() > 0 && q8[0].cyc < cyc) begin
                    chk("stale8", q8[0].cyc, cyc);
                    void'(q8.pop_front());
                end
                if (q8.size() > 0 && q8[0].cyc == cyc) begin
                    e = q8.pop_front();
                    chk("bits8", int'({b8.bit_valid, b8.x, b8.y, b8.bit_first, b8.bit_last}),
                        int'({1'b1, e.x, e.y, e.f, e.l}));
`ifdef CMP_SELFCHECK_EN
                    chk("exp8", int'({b8.exp_valid, b8.exp_eq}), int'({e.l, e.l & e.eq}));
`endif
                end else begin
                    chk("idle8", int'({b8.bit_valid, b8.x, b8.y, b8.bit_first, b8.bit_last}), 0);
`ifdef CMP_SELFCHECK_EN
                    chk("exp8_idle", int'({b8.exp_valid, b8.exp_eq}), 0);
`endif
                end

                chk("rdy1", int'(b1.in_ready), int'(!rst && cyc >= rdy1));
                chk("busy1", int'(b1.busy), int'(cyc < rdy1));
                if (q1.size() > 0 && q1[0].cyc < cyc) begin
                    chk("stale1", q1[0].cyc, cyc);
                    void'(q1.pop_front());
                end
                if (q1.size() > 0 && q1[0].cyc == cyc) begin
                    e = q1.pop_front();
                    chk("bits1", int'({b1.bit_valid, b1.x, b1.y, b1.bit_first, b1.bit_last}),
                        int'({1'b1, e.x, e.y, e.f, e.l}));
`ifdef CMP_SELFCHECK_EN
                    chk("exp1", int'({b1.exp_valid, b1.exp_eq}), int'({e.l, e.l & e.eq}));
`endif
                end else begin
                    chk("idle1", int'({b1.bit_valid, b1.x, b1.y, b1.bit_first, b1.bit_last}), 0);
                end
            end
        end
    end

    task automatic send8(input logic [W8-1:0] a, input logic [W8-1:0] b);
        b8.in_valid = 1'b1;
        b8.in_a     = a;
        b8.in_b     = b;
        tick();
        b8.in_valid = 1'b0;
    endtask

    initial begin
        b8.in_valid = 1'b0;
        b8.in_a     = '0;
        b8.in_b     = '0;
        b1.in_valid = 1'b0;
        b1.in_a     = '0;
        b1.in_b     = '0;
        rst         = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // A5/A5 on the wide lane, 1/0 on the single-bit lane
        b1.in_valid = 1'b1;
        b1.in_a     = 1'b1;
        b1.in_b     = 1'b0;
        send8(8'hA5, 8'hA5);
        b1.in_valid = 1'b0;
        repeat (12) tick();

        // Held valid: one word every W+G+1 cycles
        b8.in_valid = 1'b1;
        b8.in_a     = 8'hF0;
        b8.in_b     = 8'h0F;
        repeat (30) tick();
        b8.in_valid = 1'b0;
        repeat (12) tick();

        // Valid pulse while busy must be ignored
        send8(8'hC3, 8'h3C);
        repeat (3) tick();
        send8(8'hFF, 8'hFF);
        repeat (12) tick();

        // Reset during the 4th bit, then a fresh word
        send8(8'h3C, 8'h3C);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send8(8'h81, 8'h81);
        repeat (12) tick();

        // Equal and unequal pairs for the reference-equality outputs
        send8(8'h5A, 8'h5A);
        repeat (10) tick();
        send8(8'h5A, 8'h5B);
        repeat (12) tick();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            b8.in_valid = 1'($urandom_range(0, 1));
            b8.in_a     = 8'($urandom);
            b8.in_b     = ($urandom_range(0, 3) == 0) ? b8.in_a : 8'($urandom);
            b1.in_valid = 1'($urandom_range(0, 1));
            b1.in_a     = 1'($urandom);
            b1.in_b     = 1'($urandom);
            rst         = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst         = 1'b0;
        b8.in_valid = 1'b0;
        b1.in_valid = 1'b0;
        repeat (20) tick();
        done = 1'b1;
        repeat (5) tick();
        $display("FAIL timeout monitor did not finish");
        $fatal(1);
    end

endmodule
